// File: rtl/irrig_timer_loader_if.sv
// Digit-load and timer-control bus between the irrigation loader (master)
// and the stopwatch countdown chain (slave).
interface irrig_timer_loader_if;
  logic [1:0] dig_idx;
  logic [3:0] dig_val;
  logic       dig_valid;
  logic       dig_ready;
  logic       tmr_start;
  logic       tmr_zero;

  modport master (
    output dig_idx, dig_val, dig_valid, tmr_start,
    input  dig_ready, tmr_zero
  );

  modport slave (
    input  dig_idx, dig_val, dig_valid, tmr_start,
    output dig_ready, tmr_zero
  );
endinterface

// File: rtl/irrig_timer_loader.sv
// Samples level sensors and irrigation mode, loads an MM:SS preset into the
// countdown as four BCD digits, then runs the valve. Option: IRRIG_LEVEL_RECHECK_EN.
module irrig_timer_loader (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_req,
  input  logic                 abort,
  input  logic                 h,
  input  logic                 m,
  input  logic                 l,
  input  logic                 As,
  input  logic                 Gt,
  irrig_timer_loader_if.master tmr_bus,
  output logic                 valve,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, SAMPLE, WRITE, START, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] dur_bcd;
  logic [15:0] sel_bcd;
  logic        sel_ok;
`ifdef IRRIG_LEVEL_RECHECK_EN
  logic        h_seen;
`endif

  function automatic logic [3:0] bcd_digit(input logic [15:0] bcd, input logic [1:0] idx);
    case (idx)
      2'd3:    bcd_digit = bcd[15:12];
      2'd2:    bcd_digit = bcd[11:8];
      2'd1:    bcd_digit = bcd[7:4];
      default: bcd_digit = bcd[3:0];
    endcase
  endfunction

  // Exactly one mode and thermometer-coded levels (no level above a dry one).
  always_comb begin
    sel_ok  = (As ^ Gt) && (l || !m) && (m || !h);
    sel_bcd = 16'h0000;
    case ({h, m, l})
      3'b000:  sel_bcd = Gt ? 16'h1500 : 16'h0800;
      3'b001:  sel_bcd = Gt ? 16'h1000 : 16'h0500;
      3'b011:  sel_bcd = Gt ? 16'h0500 : 16'h0230;
      default: sel_bcd = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      dur_bcd           <= 16'h0000;
      tmr_bus.dig_idx   <= 2'd0;
      tmr_bus.dig_val   <= 4'd0;
      tmr_bus.dig_valid <= 1'b0;
      tmr_bus.tmr_start <= 1'b0;
      valve             <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
`ifdef IRRIG_LEVEL_RECHECK_EN
      h_seen            <= 1'b0;
`endif
    end else begin
      tmr_bus.tmr_start <= 1'b0;
      done              <= 1'b0;
      // Abort outranks every other event and leaves err untouched.
      if (abort && (state != IDLE)) begin
        state             <= IDLE;
        tmr_bus.dig_idx   <= 2'd0;
        tmr_bus.dig_val   <= 4'd0;
        tmr_bus.dig_valid <= 1'b0;
        valve             <= 1'b0;
        busy              <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_req) begin
              state <= SAMPLE;
              busy  <= 1'b1;
              err   <= 1'b0;
            end
          end
          SAMPLE: begin
            if (!sel_ok) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (sel_bcd == 16'h0000) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              dur_bcd           <= sel_bcd;
              tmr_bus.dig_valid <= 1'b1;
              tmr_bus.dig_idx   <= 2'd3;
              tmr_bus.dig_val   <= sel_bcd[15:12];
              state             <= WRITE;
            end
          end
          WRITE: begin
            if (tmr_bus.dig_valid && tmr_bus.dig_ready) begin
              if (tmr_bus.dig_idx == 2'd0) begin
                tmr_bus.dig_valid <= 1'b0;
                tmr_bus.dig_val   <= 4'd0;
                tmr_bus.tmr_start <= 1'b1;
                state             <= START;
              end else begin
                tmr_bus.dig_idx <= tmr_bus.dig_idx - 2'd1;
                tmr_bus.dig_val <= bcd_digit(dur_bcd, tmr_bus.dig_idx - 2'd1);
              end
            end
          end
          START: begin
            valve <= 1'b1;
            state <= RUN;
`ifdef IRRIG_LEVEL_RECHECK_EN
            h_seen <= 1'b0;
`endif
          end
          RUN: begin
            if (tmr_bus.tmr_zero) begin
              valve <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
`ifdef IRRIG_LEVEL_RECHECK_EN
            else if (h && h_seen) begin
              valve <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
            h_seen <= h;
`endif
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            valve <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irrig_timer_loader.sv
// Self-checking bench for irrig_timer_loader: directed scenarios plus randomized
// cycles checked against a seconds-based duration model.
module tb_irrig_timer_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic start_req;
  logic abort;
  logic h, m, l, As, Gt;
  logic valve, busy, done, err;

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;

  irrig_timer_loader_if bus ();

  irrig_timer_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_req (start_req),
    .abort     (abort),
    .h         (h),
    .m         (m),
    .l         (l),
    .As        (As),
    .Gt        (Gt),
    .tmr_bus   (bus),
    .valve     (valve),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit a_s, input bit g_t, input bit hh, input bit mm,
                               input bit ll, input bit sr, input bit ab);
    As = a_s; Gt = g_t; h = hh; m = mm; l = ll;
    start_req = sr;
    abort = ab;
  endtask

  // Duration in seconds from the mode/level rules; ok=0 for invalid inputs.
  function automatic int modelSeconds(input bit a_s, input bit g_t, input bit hh,
                                      input bit mm, input bit ll, output bit ok);
    int lv;
    ok = (a_s != g_t) && !(mm && !ll) && !(hh && !mm);
    lv = int'(hh) + int'(mm) + int'(ll);
    if (!ok) return 0;
    if (g_t) return 300 * (3 - lv);
    case (lv)
      0:       return 480;
      1:       return 300;
      2:       return 150;
      default: return 0;
    endcase
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"},  16'(busy), 16'd0);
    checkOutput({tag, "_valve"}, 16'(valve), 16'd0);
    checkOutput({tag, "_done"},  16'(done), 16'd0);
    checkOutput({tag, "_valid"}, 16'(bus.dig_valid), 16'd0);
    checkOutput({tag, "_idx"},   16'(bus.dig_idx), 16'd0);
    checkOutput({tag, "_val"},   16'(bus.dig_val), 16'd0);
    checkOutput({tag, "_start"}, 16'(bus.tmr_start), 16'd0);
    checkOutput({tag, "_err"},   16'(err), 16'(exp_err));
  endtask

  // end_mode: 0 tmr_zero, 1 abort with tmr_zero, 2 reset in RUN, 3 live h high in RUN
  task automatic runCycle(input bit a_s, input bit g_t, input bit hh, input bit mm, input bit ll,
                          input int ready_mode, input int run_len, input int end_mode);
    bit ok;
    int secs;
    int d[4];
    secs = modelSeconds(a_s, g_t, hh, mm, ll, ok);
    d[3] = (secs / 60) / 10;
    d[2] = (secs / 60) % 10;
    d[1] = (secs % 60) / 10;
    d[0] = secs % 10;

    applyStimulus(a_s, g_t, hh, mm, ll, 1'b1, 1'b0);
    bus.dig_ready = 1'b0;
    bus.tmr_zero  = 1'($urandom_range(0, 1));
    tick();
    start_req = 1'b0;
    exp_err = 1'b0;
    checkOutput("sample_busy", 16'(busy), 16'd1);
    checkOutput("sample_err_clr", 16'(err), 16'd0);
    checkOutput("sample_valid", 16'(bus.dig_valid), 16'd0);
    tick();

    if (!ok) begin
      exp_err = 1'b1;
      checkQuiet("invalid");
      tick();
      checkQuiet("invalid_hold");
      return;
    end

    if (secs == 0) begin
      checkOutput("zero_done", 16'(done), 16'd1);
      checkOutput("zero_valve", 16'(valve), 16'd0);
      checkOutput("zero_busy", 16'(busy), 16'd1);
      checkOutput("zero_valid", 16'(bus.dig_valid), 16'd0);
      tick();
      checkQuiet("zero_after");
      return;
    end

    for (int k = 3; k >= 0; k--) begin
      bit got;
      bit rdy;
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
        checkOutput("wr_valid", 16'(bus.dig_valid), 16'd1);
        checkOutput("wr_idx", 16'(bus.dig_idx), 16'(k));
        checkOutput("wr_val", 16'(bus.dig_val), 16'(d[k]));
        checkOutput("wr_valve", 16'(valve), 16'd0);
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = (t == 1);
          default: rdy = (t >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
        bus.dig_ready = rdy;
        bus.tmr_zero  = 1'($urandom_range(0, 1));
        tick();
        got = rdy;
      end
      if (!got) checkOutput("wr_timeout", 16'd0, 16'd1);
    end
    bus.dig_ready = 1'b0;
    bus.tmr_zero  = 1'b0;
    checkOutput("start_pulse", 16'(bus.tmr_start), 16'd1);
    checkOutput("start_valid", 16'(bus.dig_valid), 16'd0);
    checkOutput("start_idx", 16'(bus.dig_idx), 16'd0);
    checkOutput("start_val", 16'(bus.dig_val), 16'd0);
    checkOutput("start_valve", 16'(valve), 16'd0);
    tick();
    checkOutput("run_start_low", 16'(bus.tmr_start), 16'd0);
    checkOutput("run_valve", 16'(valve), 16'd1);
    checkOutput("run_busy", 16'(busy), 16'd1);

    for (int i = 0; i < run_len; i++) begin
      start_req = 1'($urandom_range(0, 1));
      tick();
      checkOutput("run_hold_valve", 16'(valve), 16'd1);
      checkOutput("run_hold_done", 16'(done), 16'd0);
    end
    start_req = 1'b0;

    case (end_mode)
      1: begin
        bus.tmr_zero = 1'b1;
        abort = 1'b1;
        tick();
        bus.tmr_zero = 1'b0;
        abort = 1'b0;
        checkQuiet("abort_run");
        tick();
        checkQuiet("abort_after");
      end
      2: begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_err = 1'b0;
        checkQuiet("reset_run");
      end
      3: begin
        h = 1'b1;
`ifdef IRRIG_LEVEL_RECHECK_EN
        tick();
        checkOutput("recheck_first_valve", 16'(valve), 16'd1);
        checkOutput("recheck_first_done", 16'(done), 16'd0);
        tick();
        h = 1'b0;
        checkOutput("recheck_done", 16'(done), 16'd1);
        checkOutput("recheck_valve", 16'(valve), 16'd0);
        tick();
        checkQuiet("recheck_after");
`else
        for (int i = 0; i < 3; i++) begin
          tick();
          checkOutput("h_ignored_valve", 16'(valve), 16'd1);
          checkOutput("h_ignored_done", 16'(done), 16'd0);
        end
        h = 1'b0;
        bus.tmr_zero = 1'b1;
        tick();
        bus.tmr_zero = 1'b0;
        checkOutput("end_done", 16'(done), 16'd1);
        checkOutput("end_valve", 16'(valve), 16'd0);
        tick();
        checkQuiet("end_after");
`endif
      end
      default: begin
        bus.tmr_zero = 1'b1;
        tick();
        bus.tmr_zero = 1'b0;
        checkOutput("end_done", 16'(done), 16'd1);
        checkOutput("end_valve", 16'(valve), 16'd0);
        checkOutput("end_busy", 16'(busy), 16'd1);
        tick();
        checkQuiet("end_after");
      end
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.dig_ready = 1'b1;
    bus.tmr_zero  = 1'b0;
    tick();
    tick();
    checkQuiet("reset");

    // Release with start_req still high: cycle begins on the first edge.
    rst_n = 1'b1;
    tick();
    start_req = 1'b0;
    checkOutput("release_busy", 16'(busy), 16'd1);
    tick();
    checkOutput("release_valid", 16'(bus.dig_valid), 16'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkQuiet("release_abort");

    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 2, 0);
    runCycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0);
    runCycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 1);
    runCycle(0, 1, 0, 1, 1, 2, 2, 3);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 2);

    // Abort during WRITE wins over a simultaneous dig_ready.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.dig_ready = 1'b0;
    tick();
    start_req = 1'b0;
    exp_err = 1'b0;
    tick();
    checkOutput("wabort_idx", 16'(bus.dig_idx), 16'd3);
    checkOutput("wabort_val", 16'(bus.dig_val), 16'd0);
    bus.dig_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.dig_ready = 1'b0;
    checkQuiet("wabort");

    for (int n = 0; n < 30; n++) begin
      runCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
